// File: rtl/lsu_sb_pipeline.sv
// Load/store unit between EXU and WBU. Stores retire into a small store buffer
// that drains in the background. Loads share a single-outstanding memory port.
module lsu_sb_pipeline #(
  parameter int ADDR_W   = 32,
  parameter int TAG_W    = 64,
  parameter int SB_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [31:0]       in_result,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [2:0]        in_funct3,
  input  logic              in_is_load,
  input  logic              in_is_store,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TAG_W-1:0]  out_tag,
  output logic [31:0]       out_result,
  output logic              out_exc,
  output logic [3:0]        out_exc_cause,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_resp_valid,
  input  logic [31:0]       mem_resp_rdata,
  output logic              sb_empty,
  input  logic              flush
);

  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int WA_W  = ADDR_W - 2;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LD_HAZ  = 3'd1;
  localparam logic [2:0] LD_REQ  = 3'd2;
  localparam logic [2:0] LD_RESP = 3'd3;
  localparam logic [2:0] DISCARD = 3'd4;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_REQ  = 2'd1;
  localparam logic [1:0] D_RESP = 2'd2;

  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'd0:    lane_mask = 4'b0001 << off;
      2'd1:    lane_mask = 4'b0011 << off;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    misaligned = (size == 2'd1 && off[0]) || (size[1] && off != 2'd0);
  endfunction

  logic [2:0]        state;
  logic [1:0]        dstate;
  logic [ADDR_W-1:0] ld_addr;
  logic [2:0]        ld_funct3;
  logic [TAG_W-1:0]  ld_tag;
  logic [WA_W-1:0]   d_word;

  logic [WA_W-1:0]     sb_addr [SB_DEPTH];
  logic [31:0]         sb_data [SB_DEPTH];
  logic [3:0]          sb_mask [SB_DEPTH];
  logic [SB_DEPTH-1:0] sb_valid;
  logic [PTR_W-1:0]    head;
  logic [PTR_W-1:0]    tail;
  logic [PTR_W:0]      count;
  logic                sb_full;

  logic                accept, in_mem, in_misal, start_load, push, pop, ld_issue, ld_done;
  logic [ADDR_W-1:0]   chk_addr;
  logic [3:0]          chk_mask;
  logic [SB_DEPTH-1:0] hit;
  logic                conflict;
  logic [31:0]         lane;
  logic [31:0]         ld_data;

  assign sb_full  = (count == (PTR_W + 1)'(SB_DEPTH));
  assign sb_empty = (count == '0) && (dstate == D_IDLE);
  assign in_ready = (state == IDLE) && (!out_valid || out_ready) && !(in_is_store && sb_full);

  // A flushed cycle kills the op being presented along with everything younger.
  assign accept     = in_valid && in_ready && !flush;
  assign in_mem     = in_is_load || in_is_store;
  assign in_misal   = in_mem && misaligned(in_funct3[1:0], in_addr[1:0]);
  assign start_load = accept && in_is_load && !in_misal;
  assign push       = accept && in_is_store && !in_misal;
  assign pop        = (dstate == D_REQ) && mem_req_ready;
  assign ld_issue   = (state == LD_REQ) && (dstate == D_IDLE) && mem_req_ready;
  assign ld_done    = (state == LD_RESP) && mem_resp_valid && !flush;

  // The same comparator serves the accept-time check and the LD_HAZ re-check.
  assign chk_addr = (state == IDLE) ? in_addr : ld_addr;
  assign chk_mask = lane_mask((state == IDLE) ? in_funct3[1:0] : ld_funct3[1:0], chk_addr[1:0]);

  genvar gi;
  generate
    for (gi = 0; gi < SB_DEPTH; gi++) begin : g_hit
      assign hit[gi] = sb_valid[gi] && (sb_addr[gi] == chk_addr[ADDR_W-1:2]) &&
                       (|(sb_mask[gi] & chk_mask));
    end
  endgenerate

  assign conflict = (|hit) || ((dstate == D_RESP) && (d_word == chk_addr[ADDR_W-1:2]));

  assign mem_req_valid = (dstate == D_REQ) || ((state == LD_REQ) && (dstate == D_IDLE));
  assign mem_req_wen   = (dstate == D_REQ);
  assign mem_req_addr  = mem_req_wen ? {sb_addr[head], 2'b00} : {ld_addr[ADDR_W-1:2], 2'b00};
  assign mem_req_wdata = mem_req_wen ? sb_data[head] : 32'd0;
  assign mem_req_wmask = mem_req_wen ? sb_mask[head] : 4'd0;

  assign lane = mem_resp_rdata >> {ld_addr[1:0], 3'b000};

  always_comb begin
    case (ld_funct3)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'd0, lane[7:0]};
      3'b101:  ld_data = {16'd0, lane[15:0]};
      default: ld_data = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ld_addr   <= '0;
      ld_funct3 <= '0;
      ld_tag    <= '0;
    end else begin
      case (state)
        IDLE: if (start_load) begin
          state     <= conflict ? LD_HAZ : LD_REQ;
          ld_addr   <= in_addr;
          ld_funct3 <= in_funct3;
          ld_tag    <= in_tag;
        end
        LD_HAZ:  if (flush) state <= IDLE; else if (!conflict) state <= LD_REQ;
        LD_REQ:  if (ld_issue) state <= flush ? DISCARD : LD_RESP; else if (flush) state <= IDLE;
        LD_RESP: if (mem_resp_valid) state <= IDLE; else if (flush) state <= DISCARD;
        DISCARD: if (mem_resp_valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Drain never starts while a load owns the port or is waiting for it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dstate <= D_IDLE;
      d_word <= '0;
    end else begin
      case (dstate)
        D_IDLE: if (count != '0 && state != LD_REQ && state != LD_RESP && state != DISCARD)
          dstate <= D_REQ;
        D_REQ: if (mem_req_ready) begin
          dstate <= D_RESP;
          d_word <= sb_addr[head];
        end
        D_RESP:  if (mem_resp_valid) dstate <= D_IDLE;
        default: dstate <= D_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      sb_valid <= '0;
    end else begin
      if (push) begin
        tail           <= tail + 1'b1;
        sb_valid[tail] <= 1'b1;
      end
      if (pop) begin
        head           <= head + 1'b1;
        sb_valid[head] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      sb_addr[tail] <= in_addr[ADDR_W-1:2];
      sb_data[tail] <= in_wdata << {in_addr[1:0], 3'b000};
      sb_mask[tail] <= lane_mask(in_funct3[1:0], in_addr[1:0]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_tag       <= '0;
      out_result    <= '0;
      out_exc       <= 1'b0;
      out_exc_cause <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept && !start_load) begin
      out_valid     <= 1'b1;
      out_tag       <= in_tag;
      out_exc       <= in_misal;
      out_exc_cause <= in_misal ? (in_is_load ? 4'd4 : 4'd6) : 4'd0;
      out_result    <= in_misal ? 32'(in_addr) : (in_is_store ? 32'd0 : in_result);
    end else if (ld_done) begin
      out_valid     <= 1'b1;
      out_tag       <= ld_tag;
      out_exc       <= 1'b0;
      out_exc_cause <= 4'd0;
      out_result    <= ld_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/lsu_sb_pipeline.md
Name: lsu_sb_pipeline

Overview:
Parametrised load/store unit for the ysyxSoC pipeline, sitting between EXU and WBU. Stores retire into a SB_DEPTH-entry store buffer and report completion downstream at once. The buffer drains to memory in the background. Loads use a shared single-outstanding memory port, stall on address conflicts with buffered stores, and raise precise misalignment exceptions. Non-memory ops pass through in one cycle.

Parameters:
ADDR_W, 32, address width (data fixed at 32 bits, RV32).
TAG_W, 64, opaque side-band (pc/rd/csr/flags) carried from input to output unchanged.
SB_DEPTH, 4, store-buffer entries; power of 2, >=2.

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid / in_ready  in / out  1 / 1  upstream handshake
in_tag  in  TAG_W  side-band
in_result  in  32  ALU/CSR result for non-mem ops
in_addr  in  ADDR_W  effective address
in_wdata  in  32  store data (unshifted rs2)
in_funct3  in  3  RV32 load/store width/sign
in_is_load / in_is_store  in  1 / 1  op class (never both)
out_valid / out_ready  out / in  1 / 1  downstream handshake
out_tag  out  TAG_W
out_result  out  32  writeback data or mtval
out_exc  out  1  misaligned exception
out_exc_cause  out  4  4 = load misaligned, 6 = store misaligned
mem_req_valid / mem_req_ready  out / in  1 / 1  memory request handshake
mem_req_wen  out  1
mem_req_addr  out  ADDR_W  word-aligned (addr[1:0]=0)
mem_req_wdata  out  32  lane-aligned data
mem_req_wmask  out  4
mem_resp_valid  in  1  one response per request, reads and writes alike
mem_resp_rdata  in  32  full word; LSU extracts lanes
sb_empty  out  1  high when buffer empty and no store outstanding (used by fence/ebreak)
flush  in  1  pipeline flush

Behaviour:
- Reset: out_valid=0, out_exc=0, out_result=0, out_tag=0, mem_req_valid=0, buffer empty, sb_empty=1, all FSMs idle.
- Main FSM states: IDLE, LD_HAZ, LD_REQ, LD_RESP, DISCARD.
- Output register holds until out_valid&&out_ready.
- in_ready = (state==IDLE) && (!out_valid||out_ready) && !(in_is_store && sb_full). The full flag is the registered value; a same-cycle pop does not count.
- Misaligned accesses produce no memory access:
  - Misaligned means: half with addr[0]!=0; word with addr[1:0]!=0.
  - Output next cycle with out_exc=1, cause 4 (load) or 6 (store), out_result = in_addr.
- Non-mem op: out_result = in_result; out_valid next cycle.
- Store accepted:
  - Pushes {addr word-aligned, wdata shifted by 8*addr[1:0], mask}. Masks: SB 0001<<off, SH 0011<<off, SW 1111.
  - Downstream out_valid next cycle with out_result=0.
- Load accepted, conflict check:
  - Conflict = any valid buffer entry with the same word address and overlapping mask, or a drain store in flight to that word.
  - Conflict -> LD_HAZ until the conflict clears; else -> LD_REQ.
- LD_REQ:
  - Waits for the drain FSM to be idle, then asserts mem_req_valid with wen=0.
  - Request fields are held stable until mem_req_ready, then -> LD_RESP.
- LD_RESP:
  - On mem_resp_valid, extract the lane using addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW takes the full word.
  - Present the output and return to IDLE (load-to-use latency is at least 3 cycles).
- Drain FSM (D_IDLE, D_REQ, D_RESP):
  - In D_IDLE with buffer non-empty, main FSM not in LD_REQ, and no load outstanding: issue the head entry.
  - Pop on the request handshake; D_RESP waits for mem_resp_valid.
- Arbitration: a load in LD_REQ beats a drain start in the same cycle. Neither preempts a request already issued.
- Simultaneous push and pop: allowed when not full; count unchanged; pointers wrap modulo SB_DEPTH.
- flush:
  - Clears out_valid and aborts the main FSM.
  - An issued-but-unanswered load -> DISCARD, which swallows one mem_resp_valid and then -> IDLE.
  - An unissued load returns to IDLE immediately.
  - Buffer contents and the drain FSM are unaffected, because stores are already committed.
- Reset mid-transaction: everything returns to reset values; outstanding responses are the interconnect's concern.

Test Plan:
- SW 0xDEADBEEF @0x80000004, out_ready=1 -> out_valid next cycle; later mem request addr 0x80000004, wmask 1111, wdata 0xDEADBEEF; sb_empty returns to 1 after the response.
- SB 0xAB @0x80000003, then LBU @0x80000003 -> load waits in LD_HAZ until the drain response; store wmask 1000, wdata 0xAB000000; memory returns 0xAB000000 -> out_result 0x000000AB.
- LH @0x100 with rdata 0x80000000... wait case: LH @0x102 with rdata 0x8001_0000 -> out_result 0xFFFF8001; LHU -> 0x00008001.
- Five SWs back-to-back, mem_req_ready=0, SB_DEPTH=4 -> four accepted; in_ready=0 on the fifth until the first pop; non-mem ops still accepted.
- LW @0x103 -> no mem_req_valid; out_exc=1, cause 4, out_result 0x103. SH @0x101 -> cause 6.
- Load issued, flush before the response -> no out_valid; the response is swallowed; the next op completes normally; the pending buffered store still drains.
